// File: rtl/packet_receiver.sv
// packet_receiver: UART byte deserialiser and cmd/len/payload parser that writes payload bytes to a byte RAM.
// Optional feature: define RX_CHECKSUM_EN to require a trailing XOR checksum byte on every packet.
module packet_receiver #(
    parameter int    CLOCK     = 50_000_000,
    parameter int    BAUD      = 115_200,
    parameter string PARITY    = "NO",
    parameter string FIRST_BIT = "LSB",
    parameter int    NUMBER    = 256,
    parameter int    TIMEOUT   = 0,
    localparam int   AW        = $clog2(NUMBER)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rxd,
    output logic [7:0]    cmd_rx,
    output logic [7:0]    len_rx,
    output logic [7:0]    wr_data,
    output logic [AW-1:0] wr_addr,
    output logic          wr_en,
    output logic          pckt_done,
    output logic          pckt_err,
    output logic          busy
);

    localparam int DIV  = CLOCK / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
    localparam bit PAR_EN    = (PARITY != "NO");
    localparam bit PAR_ODD   = (PARITY == "ODD");
    localparam bit MSB_FIRST = (FIRST_BIT == "MSB");

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;
`ifdef RX_CHECKSUM_EN
    typedef enum logic [1:0] {S_CMD, S_LEN, S_DATA, S_CSUM} pkt_state_t;
`else
    typedef enum logic [1:0] {S_CMD, S_LEN, S_DATA} pkt_state_t;
`endif

    rx_state_t     rx_state;
    pkt_state_t    state;
    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_byte;
    logic          par_ok;
    logic          rx_fall, bit_hit, start_ok, byte_vld, byte_err;
    logic [CW-1:0] tmo_cyc;
    logic [15:0]   tmo_per;
    logic          tmo_run, timeout;
    logic [AW:0]   index;
    logic [7:0]    remaining;
    logic [7:0]    csum;
    logic          overflow;

    assign rx_fall  = rx_prev && !rx_sync;
    assign bit_hit  = (baud_cnt == BIT_END);
    assign start_ok = (rx_state == R_START) && (baud_cnt == HALF_END) && !rx_sync;
    assign byte_vld = (rx_state == R_STOP) && bit_hit && rx_sync && par_ok;
    assign byte_err = (rx_state == R_STOP) && bit_hit && !(rx_sync && par_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Start is confirmed half a bit after the falling edge; every later sample lands one full bit on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= R_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            rx_byte  <= '0;
            par_ok   <= 1'b1;
        end else begin
            case (rx_state)
                R_IDLE: begin
                    baud_cnt <= '0;
                    if (rx_fall) rx_state <= R_START;
                end
                R_START: begin
                    if (baud_cnt == HALF_END) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        par_ok   <= 1'b1;
                        rx_state <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (bit_hit) begin
                        baud_cnt <= '0;
                        rx_byte  <= MSB_FIRST ? {rx_byte[6:0], rx_sync} : {rx_sync, rx_byte[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= PAR_EN ? R_PAR : R_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                R_PAR: begin
                    if (bit_hit) begin
                        baud_cnt <= '0;
                        par_ok   <= (((^rx_byte) ^ rx_sync) == PAR_ODD);
                        rx_state <= R_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (bit_hit) begin
                        baud_cnt <= '0;
                        rx_state <= R_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // The timer only runs mid-packet while the line is idle, so any byte in flight holds it at zero.
    assign tmo_run = (TIMEOUT != 0) && (state != S_CMD) && (rx_state == R_IDLE) && !rx_fall;
    assign timeout = tmo_run && (tmo_cyc == BIT_END) && (int'(tmo_per) == TIMEOUT - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cyc <= '0;
            tmo_per <= '0;
        end else if (!tmo_run) begin
            tmo_cyc <= '0;
            tmo_per <= '0;
        end else if (tmo_cyc == BIT_END) begin
            tmo_cyc <= '0;
            tmo_per <= tmo_per + 1'b1;
        end else begin
            tmo_cyc <= tmo_cyc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_CMD;
            cmd_rx    <= '0;
            len_rx    <= '0;
            wr_data   <= '0;
            wr_addr   <= '0;
            wr_en     <= 1'b0;
            pckt_done <= 1'b0;
            pckt_err  <= 1'b0;
            busy      <= 1'b0;
            index     <= '0;
            remaining <= '0;
            csum      <= '0;
            overflow  <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            pckt_done <= 1'b0;
            pckt_err  <= 1'b0;
            if (start_ok) busy <= 1'b1;
            if (byte_err || timeout) begin
                pckt_err <= 1'b1;
                busy     <= 1'b0;
                state    <= S_CMD;
            end else if (byte_vld) begin
                case (state)
                    S_CMD: begin
                        cmd_rx <= rx_byte;
                        csum   <= rx_byte;
                        state  <= S_LEN;
                    end
                    S_LEN: begin
                        len_rx    <= rx_byte;
                        csum      <= csum ^ rx_byte;
                        index     <= '0;
                        remaining <= rx_byte;
                        overflow  <= (int'(rx_byte) > NUMBER);
                        if (rx_byte != 8'd0) begin
                            state <= S_DATA;
                        end else begin
`ifdef RX_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state     <= S_CMD;
                            busy      <= 1'b0;
                            pckt_done <= 1'b1;
`endif
                        end
                    end
                    S_DATA: begin
                        csum      <= csum ^ rx_byte;
                        remaining <= remaining - 8'd1;
                        // Overlength bytes are swallowed without a write; index parks at NUMBER.
                        if (int'(index) < NUMBER) begin
                            wr_en   <= 1'b1;
                            wr_data <= rx_byte;
                            wr_addr <= index[AW-1:0];
                            index   <= index + 1'b1;
                        end
                        if (remaining == 8'd1) begin
`ifdef RX_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state     <= S_CMD;
                            busy      <= 1'b0;
                            pckt_done <= !overflow;
                            pckt_err  <= overflow;
`endif
                        end
                    end
`ifdef RX_CHECKSUM_EN
                    S_CSUM: begin
                        state <= S_CMD;
                        busy  <= 1'b0;
                        if ((rx_byte == csum) && !overflow) pckt_done <= 1'b1;
                        else pckt_err <= 1'b1;
                    end
`endif
                    default: state <= S_CMD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_packet_receiver.sv
// tb_packet_receiver: drives UART packets into packet_receiver and checks writes/strobes against a packet-level model.
// Honours RX_CHECKSUM_EN by appending (and sometimes corrupting) the XOR checksum byte.
module tb_packet_receiver;

    localparam int CLOCK   = 1_000_000;
    localparam int BAUD    = 100_000;
    localparam int DIV     = CLOCK / BAUD;
    localparam int NUMBER  = 16;
    localparam int TIMEOUT = 4;
    localparam int AW      = $clog2(NUMBER);
`ifdef RX_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rxd = 1'b1;
    logic [7:0]    cmd_rx, len_rx, wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_en, pckt_done, pckt_err, busy;

    packet_receiver #(
        .CLOCK(CLOCK), .BAUD(BAUD), .PARITY("NO"), .FIRST_BIT("LSB"),
        .NUMBER(NUMBER), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .rxd(rxd),
        .cmd_rx(cmd_rx), .len_rx(len_rx), .wr_data(wr_data), .wr_addr(wr_addr),
        .wr_en(wr_en), .pckt_done(pckt_done), .pckt_err(pckt_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, evt_cyc = 0;
    int stop_start_cyc = 0, last_end_cyc = 0;
    logic [15:0] wr_q[$];
    logic [7:0]  pkt_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobes are logged mid-cycle; expectPacket compares the log with the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) wr_q.push_back({8'(wr_addr), wr_data});
            if ((pckt_done || pckt_err) && (done_cnt + err_cnt) == 0) evt_cyc = cyc;
            if (pckt_done) done_cnt++;
            if (pckt_err) err_cnt++;
            if (pckt_done && pckt_err) both_cnt++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearMon();
        wr_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        both_cnt = 0;
    endtask

    task automatic sendByte(input logic [7:0] b, input bit bad_stop);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        stop_start_cyc = cyc;
        rxd = !bad_stop;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
        last_end_cyc = cyc;
    endtask

    task automatic addCsum();
        logic [7:0] x;
        x = 8'h00;
        foreach (pkt_q[k]) x ^= pkt_q[k];
        if (CS == 1) pkt_q.push_back(x);
    endtask

    task automatic applyStimulus(input int bad_at, input int max_gap);
        foreach (pkt_q[k]) begin
            sendByte(pkt_q[k], k == bad_at);
            if (k == 0 && bad_at != 0 && pkt_q.size() > 1) checkOutput("busy_mid", {31'd0, busy}, 32'd1);
            if (k + 1 < pkt_q.size() && max_gap > 0) repeat ($urandom_range(0, max_gap) * DIV) @(negedge clk);
        end
    endtask

    task automatic expectPacket(input string name, input int bad_at);
        int n, len, full;
        bit ok;
        logic [7:0]  x;
        logic [15:0] exp_q[$];
        n    = pkt_q.size();
        len  = int'(pkt_q[1]);
        full = 2 + len + CS;
        for (int c = 0; c < (TIMEOUT + 3) * DIV && (done_cnt + err_cnt) == 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        for (int i = 0; i < len && i < NUMBER; i++)
            if (2 + i < n && (bad_at < 0 || 2 + i < bad_at)) exp_q.push_back({8'(i), pkt_q[2 + i]});
        ok = (bad_at < 0) && (n >= full) && (len <= NUMBER);
        if (ok && CS == 1) begin
            x = 8'h00;
            for (int i = 0; i < 2 + len; i++) x ^= pkt_q[i];
            ok = (pkt_q[2 + len] == x);
        end
        checkOutput({name, " wr_count"}, wr_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < wr_q.size(); j++)
            checkOutput({name, " wr_addr_data"}, 32'(wr_q[j]), 32'(exp_q[j]));
        checkOutput({name, " done"}, done_cnt, ok ? 1 : 0);
        checkOutput({name, " err"}, err_cnt, ok ? 0 : 1);
        checkOutput({name, " done_err_same_cycle"}, both_cnt, 0);
        checkOutput({name, " busy_after"}, {31'd0, busy}, 32'd0);
        if (bad_at < 0 || bad_at >= 2) begin
            checkOutput({name, " cmd_rx"}, {24'd0, cmd_rx}, {24'd0, pkt_q[0]});
            checkOutput({name, " len_rx"}, {24'd0, len_rx}, {24'd0, pkt_q[1]});
        end
        clearMon();
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, " wr_en"}, {31'd0, wr_en}, 32'd0);
        checkOutput({name, " pckt_done"}, {31'd0, pckt_done}, 32'd0);
        checkOutput({name, " pckt_err"}, {31'd0, pckt_err}, 32'd0);
        checkOutput({name, " busy"}, {31'd0, busy}, 32'd0);
        checkOutput({name, " cmd_rx"}, {24'd0, cmd_rx}, 32'd0);
        checkOutput({name, " len_rx"}, {24'd0, len_rx}, 32'd0);
        checkOutput({name, " wr_data"}, {24'd0, wr_data}, 32'd0);
        checkOutput({name, " wr_addr"}, 32'(wr_addr), 32'd0);
    endtask

    initial begin
        int delta;
        repeat (4) @(negedge clk);
        checkResetOutputs("reset");
        reset = 1'b0;
        repeat (2 * DIV) @(negedge clk);
        clearMon();

        pkt_q = {8'h5A, 8'h03, 8'h11, 8'h22, 8'h33};
        addCsum();
        applyStimulus(-1, 0);
        expectPacket("basic", -1);

        pkt_q = {8'h07, 8'h00};
        addCsum();
        applyStimulus(-1, 0);
        expectPacket("len0", -1);
        delta = evt_cyc - stop_start_cyc;
        checkOutput("len0_latency_window", (delta >= DIV / 2 && delta <= DIV + 3) ? 1 : 0, 1);

        pkt_q = {8'h5A, 8'h02, 8'hAA};
        applyStimulus(2, 0);
        expectPacket("bad_stop", 2);
        repeat (2 * DIV) @(negedge clk);

        pkt_q = {8'h01, 8'h01, 8'h44};
        addCsum();
        applyStimulus(-1, 0);
        expectPacket("after_err", -1);

        pkt_q = {8'h5A, 8'h02, 8'hAA};
        applyStimulus(-1, 0);
        expectPacket("timeout", -1);
        delta = evt_cyc - last_end_cyc;
        checkOutput("timeout_window", (delta >= (TIMEOUT - 1) * DIV && delta <= TIMEOUT * DIV + DIV / 2) ? 1 : 0, 1);

        pkt_q = {8'hC3, 8'd18};
        for (int i = 0; i < 18; i++) pkt_q.push_back(8'($urandom));
        addCsum();
        applyStimulus(-1, 0);
        expectPacket("overlen", -1);

`ifdef RX_CHECKSUM_EN
        pkt_q = {8'h5A, 8'h01, 8'h10, 8'h4B};
        applyStimulus(-1, 0);
        expectPacket("csum_good", -1);
        pkt_q = {8'h5A, 8'h01, 8'h10, 8'h4C};
        applyStimulus(-1, 0);
        expectPacket("csum_bad", -1);
`endif

        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        checkOutput("glitch wr_count", wr_q.size(), 0);
        checkOutput("glitch done", done_cnt, 0);
        checkOutput("glitch err", err_cnt, 0);
        checkOutput("glitch busy", {31'd0, busy}, 32'd0);
        clearMon();

        pkt_q = {8'h5A, 8'h04, 8'h11, 8'h22};
        applyStimulus(-1, 0);
        repeat (2) @(negedge clk);
        checkOutput("rst_mid pre_writes", wr_q.size(), 2);
        reset = 1'b1;
        @(negedge clk);
        checkResetOutputs("rst_mid");
        reset = 1'b0;
        repeat (DIV) @(negedge clk);
        clearMon();
        pkt_q = {8'h01, 8'h02, 8'h33, 8'h44};
        addCsum();
        applyStimulus(-1, 0);
        expectPacket("post_reset", -1);

        for (int r = 0; r < 10; r++) begin
            int len;
            len = $urandom_range(0, 20);
            pkt_q = {8'($urandom), 8'(len)};
            for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
            addCsum();
            if (CS == 1 && $urandom_range(0, 3) == 0) pkt_q[pkt_q.size() - 1] = pkt_q[pkt_q.size() - 1] ^ 8'h5C;
            applyStimulus(-1, 2);
            expectPacket("random", -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
